// File: rtl/adder_arbiter_pkg.sv
// Shared types and sizing helpers for the adder_arbiter block.
// Holds the response FSM states and default geometry.
package adder_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    function automatic int idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin grant selection: first requester at or after ptr wins.
// Purely combinational; ptr is always kept below NREQ by the owner.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    always_comb begin
        int p;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        p      = int'(ptr);
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (i == (p + k) % NREQ)) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    gnt_id = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one W-bit adder among NREQ requesters with a registered response.
// Define ADDER_ARBITER_SAT_EN for a saturating sum (carry still reported).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    parameter int  W    = W_DEF,
    localparam int IDW  = idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any;
    logic            can_accept;
    logic            xfer;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W:0]      sum_full;
    logic [W-1:0]    sum_res;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Reset gates accept so no requester sees ready while rst is high.
    assign can_accept = !rst && ((state == IDLE) || rsp_ready);
    assign xfer       = any && can_accept;
    assign req_ready  = can_accept ? gnt : '0;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_a = req_a[i*W +: W];
                op_b = req_b[i*W +: W];
            end
        end
    end

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_ARBITER_SAT_EN
    assign sum_res = sum_full[W] ? '1 : sum_full[W-1:0];
`else
    assign sum_res = sum_full[W-1:0];
`endif

    assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        state     <= HOLD;
                        rsp_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!xfer && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
            endcase
            if (xfer) begin
                ptr       <= ptr_next;
                rsp_sum   <= sum_res;
                rsp_carry <= sum_full[W];
                rsp_id    <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized + directed bench for adder_arbiter against a reference model.
// Expected sums follow ADDER_ARBITER_SAT_EN when it is defined.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = idw(NREQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic [IDW-1:0]    rsp_id;

    adder_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit           m_hold  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    bit           m_carry = 1'b0;
    int           m_id    = 0;
    int           m_ptr   = 0;
    int           last_g  = -1;
    int           n_id1   = 0;
    logic [NREQ-1:0] obs_ready;
    logic [W-1:0] held_sum;
    int           held_id;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_sum(input int s);
`ifdef ADDER_ARBITER_SAT_EN
        if (s >= (1 << W)) return '1;
`endif
        return W'(s);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 8)
            0: return 8'hFF;
            1: return 8'h01;
            2: return 8'h80;
            3: return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    // One clock: check at the falling edge, update the model at the rising one.
    task automatic cyc();
        int g;
        bit can;
        int s;
        @(negedge clk);
        can = !m_hold || rsp_ready;
        g   = m_winner();
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), (can && g >= 0) ? (32'd1 << g) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
        if (m_hold) begin
            chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (rsp_valid && rsp_id == IDW'(1)) n_id1++;
        @(posedge clk);
        last_g = -1;
        if (can && g >= 0) begin
            s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            m_sum   = ref_sum(s);
            m_carry = (s >= (1 << W));
            m_id    = g;
            m_hold  = 1'b1;
            m_ptr   = (g + 1) % NREQ;
            last_g  = g;
        end else if (rsp_ready) begin
            m_hold = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_ptr  = 0;
    endtask

    task automatic all_req();
        for (int i = 0; i < NREQ; i++) set_req(i, W'(8'h10 * (i + 1)), W'(i + 3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        all_req();
        #2;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) chk("first_gnt", 32'(obs_ready), 32'h1);
            chk("rr_id", 32'(rsp_id), k % NREQ);
            chk("rr_valid", 32'(rsp_valid), 1);
        end

        // Async reset while a result is held.
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(req_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        chk("post_rst_gnt", 32'(obs_ready), 32'h1);
        chk("post_rst_id", 32'(rsp_id), 0);

        req_valid = '0;
        cyc();
        cyc();
        set_req(2, 8'h12, 8'h34);
        cyc();
        req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_sum", 32'(rsp_sum), 32'h46);
        chk("single_carry", 32'(rsp_carry), 0);
        chk("single_id", 32'(rsp_id), 2);
        cyc();
        chk("single_drop", 32'(rsp_valid), 0);

        set_req(0, 8'hFF, 8'h01);
        cyc();
        req_valid = '0;
`ifdef ADDER_ARBITER_SAT_EN
        chk("ovf1_sum", 32'(rsp_sum), 32'hFF);
`else
        chk("ovf1_sum", 32'(rsp_sum), 32'h00);
`endif
        chk("ovf1_carry", 32'(rsp_carry), 1);
        set_req(3, 8'h80, 8'h80);
        cyc();
        req_valid = '0;
`ifdef ADDER_ARBITER_SAT_EN
        chk("ovf2_sum", 32'(rsp_sum), 32'hFF);
`else
        chk("ovf2_sum", 32'(rsp_sum), 32'h00);
`endif
        chk("ovf2_carry", 32'(rsp_carry), 1);
        chk("ovf2_id", 32'(rsp_id), 3);
        cyc();

        // Backpressure with all requesting.
        all_req();
        rsp_ready = 1'b0;
        cyc();
        held_sum = rsp_sum;
        held_id  = int'(rsp_id);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_ready", 32'(obs_ready), 0);
            chk("bp_sum", 32'(rsp_sum), 32'(held_sum));
            chk("bp_id", 32'(rsp_id), held_id);
        end
        rsp_ready = 1'b1;
        cyc();
        chk("bp_release", 32'(obs_ready), 32'd1 << ((held_id + 1) % NREQ));

        // Withdrawal: requester 1 asks during backpressure then leaves.
        req_valid = '0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h05, 8'h06);
        cyc();
        req_valid = '0;
        n_id1 = 0;
        set_req(1, 8'h33, 8'h44);
        cyc();
        chk("wd_ready", 32'(obs_ready), 0);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("wd_no_id1", 32'(n_id1), 0);
        all_req();
        cyc();
        chk("wd_ptr", 32'(obs_ready), 32'h2);
        req_valid = '0;
        cyc();

        for (int n = 0; n < 500; n++) begin
            rsp_ready = ($urandom % 10) < 7;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if ($urandom % 16 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    set_req(i, rnd_op(), rnd_op());
                end
            end
            cyc();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
